// File: rtl/ibm1620_timing_pkg.sv
// Shared definitions for the IBM 1620 memory-cycle timing ring: controller
// states and the timing-position index constants T0..T9.
package ibm1620_timing_pkg;

   localparam int RING_LEN_DEF = 10;

   localparam int T0 = 0;
   localparam int T1 = 1;
   localparam int T2 = 2;
   localparam int T3 = 3;
   localparam int T4 = 4;
   localparam int T5 = 5;
   localparam int T6 = 6;
   localparam int T7 = 7;
   localparam int T8 = 8;
   localparam int T9 = 9;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_e;

endpackage

// File: rtl/ibm1620_trig_sync.sv
// Binary-trigger receiver: 2-flop synchroniser, rising-edge detector,
// saturating period counter, period lock and stall detection.
module ibm1620_trig_sync #(
   parameter int PER_W      = 8,
   parameter int LOCK_EDGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             trig_i,
   input  logic             running_i,
   output logic             edge_o,
   output logic             locked_o,
   output logic [PER_W-1:0] lock_per_o,
   output logic             stall_o
);

   localparam int MW = $clog2(LOCK_EDGES + 1);

   logic             sync1_q, sync2_q, sync3_q;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [PER_W-1:0] last_per_q, last_per_d;
   logic [PER_W-1:0] lock_per_q, lock_per_d;
   logic [MW-1:0]    match_q, match_d;
   logic             have_edge_q, have_edge_d;
   logic             locked_q, locked_d;
   logic             edge_w, per_sat, stall_w;
   logic [PER_W:0]   stall_lim;

   assign edge_w    = sync2_q & ~sync3_q;
   assign per_sat   = &per_cnt_q;
   // 2*lock_per+1 as a shift with a one shifted in.
   assign stall_lim = {lock_per_q, 1'b1};
   assign stall_w   = running_i & locked_q & ~edge_w & ({1'b0, per_cnt_q} >= stall_lim);

   // Synchroniser chain plus one delay stage for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so each flop samples its predecessor's pre-edge value.
         sync1_q <= trig_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Period counter and lock state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         per_cnt_q   <= '0;
         last_per_q  <= '0;
         lock_per_q  <= '0;
         match_q     <= '0;
         have_edge_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         per_cnt_q   <= per_cnt_d;
         last_per_q  <= last_per_d;
         lock_per_q  <= lock_per_d;
         match_q     <= match_d;
         have_edge_q <= have_edge_d;
         locked_q    <= locked_d;
      end
   end

   // Interval measurement and lock decision; a saturated interval never counts.
   always_comb begin
      // NOTE: every target defaults to its held value first, so no latch is inferred.
      per_cnt_d   = per_cnt_q;
      last_per_d  = last_per_q;
      lock_per_d  = lock_per_q;
      match_d     = match_q;
      have_edge_d = have_edge_q;
      locked_d    = locked_q;

      if (edge_w) begin
         per_cnt_d   = PER_W'(1);
         have_edge_d = 1'b1;
         if (have_edge_q && !per_sat) begin
            last_per_d = per_cnt_q;
            if (per_cnt_q == last_per_q && match_q != '0) begin
               if (match_q < MW'(LOCK_EDGES)) match_d = match_q + 1'b1;
            end else begin
               match_d = MW'(1);
            end
            if (!locked_q && match_d >= MW'(LOCK_EDGES)) begin
               locked_d   = 1'b1;
               lock_per_d = per_cnt_q;
            end
         end else begin
            match_d = '0;
         end
      end else if (!per_sat) begin
         per_cnt_d = per_cnt_q + 1'b1;
      end

      if (stall_w) begin
         locked_d = 1'b0;
         match_d  = '0;
      end
   end

   assign edge_o     = edge_w;
   assign locked_o   = locked_q;
   assign lock_per_o = lock_per_q;
   assign stall_o    = stall_w;

endmodule

// File: rtl/ibm1620_timing_ring.sv
// IBM 1620 timing ring: steps a one-hot gate ring T0..T(RING_LEN-1) on each
// synchronised trigger edge, with run/stop/single-cycle control and stall
// recovery. Define IBM1620_RING_CHECK_EN to add the one-hot ring check.
module ibm1620_timing_ring
   import ibm1620_timing_pkg::*;
#(
   parameter int RING_LEN   = RING_LEN_DEF,
   parameter int PER_W      = 8,
   parameter int LOCK_EDGES = 2
) (
   input  logic                SYSCLOCK,
   input  logic                SYSRESET_N,
   input  logic                trig_q,
   input  logic                run_req,
   input  logic                stop_req,
   input  logic                single_cycle,
   output logic [RING_LEN-1:0] ring,
   output logic                cycle_end,
   output logic                running,
   output logic                locked,
   output logic                stall_err,
   output logic                ring_chk_err
);

   localparam logic [RING_LEN-1:0] RING_T0 = RING_LEN'(1) << T0;

   state_e              state_q, state_d;
   logic [RING_LEN-1:0] ring_q, ring_d;
   logic                cycle_end_q, cycle_end_d;
   logic                stall_err_q, stall_err_d;
   logic                edge_w, locked_w, stall_w;
   logic                advance, wrap;
   logic [PER_W-1:0]    lock_per_w;
   logic                lock_per_unused;
`ifdef IBM1620_RING_CHECK_EN
   logic                chk_err_q, chk_err_d, chk_fail;
`endif

   ibm1620_trig_sync #(
      .PER_W      (PER_W),
      .LOCK_EDGES (LOCK_EDGES)
   ) u_trig_sync (
      .clk_i      (SYSCLOCK),
      .rst_ni     (SYSRESET_N),
      .trig_i     (trig_q),
      .running_i  (running),
      .edge_o     (edge_w),
      .locked_o   (locked_w),
      .lock_per_o (lock_per_w),
      .stall_o    (stall_w)
   );

   // Locked period is exported for observation only; the ring itself does not use it.
   assign lock_per_unused = ^lock_per_w;

   assign advance = edge_w && (state_q != ST_IDLE);
   assign wrap    = advance && ring_q[RING_LEN-1];
`ifdef IBM1620_RING_CHECK_EN
   assign chk_fail = (ring_q == '0) || ((ring_q & (ring_q - 1'b1)) != '0);
`endif

   // State register: controller state, ring, cycle_end pulse and sticky flags.
   always_ff @(posedge SYSCLOCK or negedge SYSRESET_N) begin
      if (!SYSRESET_N) begin
         state_q     <= ST_IDLE;
         ring_q      <= RING_T0;
         cycle_end_q <= 1'b0;
         stall_err_q <= 1'b0;
`ifdef IBM1620_RING_CHECK_EN
         chk_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ring_q      <= ring_d;
         cycle_end_q <= cycle_end_d;
         stall_err_q <= stall_err_d;
`ifdef IBM1620_RING_CHECK_EN
         chk_err_q   <= chk_err_d;
`endif
      end
   end

   // Next state: run control, ring rotation, then stall/check recovery override.
   always_comb begin
      state_d     = state_q;
      ring_d      = ring_q;
      cycle_end_d = 1'b0;
      stall_err_d = stall_err_q;
`ifdef IBM1620_RING_CHECK_EN
      chk_err_d   = chk_err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            ring_d = RING_T0;
            if (run_req && locked_w)           state_d = ST_RUN;
            else if (single_cycle && locked_w) state_d = ST_STOPPING;
         end
         // A stop seen on the wrap tick lands in STOPPING, so one more full cycle runs.
         ST_RUN:      if (stop_req || !run_req) state_d = ST_STOPPING;
         ST_STOPPING: if (wrap) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase

      if (advance) begin
         ring_d      = {ring_q[RING_LEN-2:0], ring_q[RING_LEN-1]};
         cycle_end_d = wrap;
      end

      if (stall_w) begin
         state_d     = ST_IDLE;
         ring_d      = RING_T0;
         cycle_end_d = 1'b0;
         stall_err_d = 1'b1;
      end

`ifdef IBM1620_RING_CHECK_EN
      if (chk_fail) begin
         state_d     = ST_IDLE;
         ring_d      = RING_T0;
         cycle_end_d = 1'b0;
         chk_err_d   = 1'b1;
      end
`endif
   end

   // Outputs decoded from registered state.
   always_comb begin
      ring         = ring_q;
      cycle_end    = cycle_end_q;
      running      = (state_q != ST_IDLE);
      locked       = locked_w;
      stall_err    = stall_err_q;
`ifdef IBM1620_RING_CHECK_EN
      ring_chk_err = chk_err_q;
`else
      ring_chk_err = 1'b0;
`endif
   end

endmodule

// File: tb/tb_ibm1620_timing_ring.sv
// Self-checking bench for ibm1620_timing_ring: table-driven ring stepping plus
// directed sequences for stop, wrap-coincident stop, single cycle, stall,
// mid-cycle reset, unlocked requests and saturated-period rejection.
module tb_ibm1620_timing_ring;

   localparam logic [9:0] R_T0 = 10'h001;
   localparam logic [9:0] R_T2 = 10'h004;
   localparam logic [9:0] R_T3 = 10'h008;
   localparam logic [9:0] R_T4 = 10'h010;
   localparam logic [9:0] R_T6 = 10'h040;
   localparam logic [9:0] R_T9 = 10'h200;

   logic       SYSCLOCK;
   logic       SYSRESET_N;
   logic       trig_q;
   logic       run_req;
   logic       stop_req;
   logic       single_cycle;
   logic [9:0] ring;
   logic       cycle_end;
   logic       running;
   logic       locked;
   logic       stall_err;
   logic       ring_chk_err;

   int checks   = 0;
   int failures = 0;
   int tick_cnt = 0;
   bit trig_en  = 1'b0;
   int trig_per = 8;
   int trig_phase = 0;

   typedef struct {
      logic [9:0] exp_ring;
      logic       exp_ce;
   } step_t;

   step_t steps[12];

   ibm1620_timing_ring dut (
      .SYSCLOCK     (SYSCLOCK),
      .SYSRESET_N   (SYSRESET_N),
      .trig_q       (trig_q),
      .run_req      (run_req),
      .stop_req     (stop_req),
      .single_cycle (single_cycle),
      .ring         (ring),
      .cycle_end    (cycle_end),
      .running      (running),
      .locked       (locked),
      .stall_err    (stall_err),
      .ring_chk_err (ring_chk_err)
   );

   initial SYSCLOCK = 1'b0;
   always #5 SYSCLOCK = ~SYSCLOCK;
   always @(posedge SYSCLOCK) tick_cnt++;

   // Trigger source: high for the first half of each trig_per-tick period.
   always @(negedge SYSCLOCK) begin
      if (trig_en) begin
         trig_q = (trig_phase < trig_per / 2);
         trig_phase = (trig_phase + 1 >= trig_per) ? 0 : trig_phase + 1;
      end else begin
         trig_q = 1'b0;
         trig_phase = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge SYSCLOCK);
   endtask

   task automatic wait_running(input logic val, input int bound, input string name);
      bit found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (running === val) begin
            found = 1'b1;
            break;
         end
      end
      check(name, {31'd0, found}, 32'd1);
   endtask

   task automatic wait_ring(input logic [9:0] want, input int bound, input string name);
      bit found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (ring === want) begin
            found = 1'b1;
            break;
         end
      end
      check(name, {31'd0, found}, 32'd1);
   endtask

   task automatic wait_cycle_end(input int bound, input string name);
      bit found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (cycle_end === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check(name, {31'd0, found}, 32'd1);
   endtask

   // Counts ring advances and cycle_end pulses until running drops after being seen high.
   task automatic run_until_idle(input int bound, input string name, output int adv, output int ce);
      logic [9:0] prev;
      bit seen, done;
      prev = ring;
      seen = running;
      done = 1'b0;
      adv  = 0;
      ce   = 0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (ring !== prev) adv++;
         prev = ring;
         if (cycle_end === 1'b1) ce++;
         if (running === 1'b1) seen = 1'b1;
         else if (seen) begin
            done = 1'b1;
            break;
         end
      end
      check({name, "_reached_idle"}, {31'd0, done}, 32'd1);
   endtask

   task automatic pulse_reset();
      tick();
      SYSRESET_N = 1'b0;
      tick();
      SYSRESET_N = 1'b1;
   endtask

   initial begin
      int adv, ce, t1, t2, elapsed, bad, run_ticks, lock_ticks;
      bit got;
      logic [9:0] prev;

      steps[0]  = '{10'h002, 1'b0};
      steps[1]  = '{10'h004, 1'b0};
      steps[2]  = '{10'h008, 1'b0};
      steps[3]  = '{10'h010, 1'b0};
      steps[4]  = '{10'h020, 1'b0};
      steps[5]  = '{10'h040, 1'b0};
      steps[6]  = '{10'h080, 1'b0};
      steps[7]  = '{10'h100, 1'b0};
      steps[8]  = '{10'h200, 1'b0};
      steps[9]  = '{10'h001, 1'b1};
      steps[10] = '{10'h002, 1'b0};
      steps[11] = '{10'h004, 1'b0};

      SYSRESET_N   = 1'b0;
      run_req      = 1'b0;
      stop_req     = 1'b0;
      single_cycle = 1'b0;
      trig_q       = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_ring", ring, R_T0);
      check("rst_running", running, 0);
      check("rst_locked", locked, 0);
      check("rst_cycle_end", cycle_end, 0);
      check("rst_stall_err", stall_err, 0);
      check("rst_ring_chk_err", ring_chk_err, 0);
      SYSRESET_N = 1'b1;

      // Lock at period 8 and free-run
      trig_en = 1'b1;
      run_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         check("no_run_before_lock", {31'd0, running & ~locked}, 0);
         if (locked === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("lock_achieved", {31'd0, got}, 1);
      wait_running(1'b1, 5, "enter_run");
      check("run_starts_t0", ring, R_T0);

      for (int k = 0; k < 12; k++) begin
         prev = ring;
         got = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (ring !== prev) begin
               got = 1'b1;
               break;
            end
         end
         check($sformatf("step%0d_advanced", k + 1), {31'd0, got}, 1);
         check($sformatf("step%0d_ring", k + 1), ring, steps[k].exp_ring);
         check($sformatf("step%0d_cycle_end", k + 1), cycle_end, steps[k].exp_ce);
      end

      wait_cycle_end(100, "cycle_end_a");
      t1 = tick_cnt;
      wait_cycle_end(100, "cycle_end_b");
      t2 = tick_cnt;
      check("cycle_period_ticks", t2 - t1, 80);

      // stop_req pulse at T4 finishes the cycle (run_req stays high)
      wait_ring(R_T4, 100, "reach_t4");
      stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
      run_until_idle(200, "stop_t4", adv, ce);
      run_req = 1'b0;
      check("stop_t4_advances", adv, 6);
      check("stop_t4_cycle_end", ce, 1);
      check("stop_t4_ring", ring, R_T0);
      repeat (3) tick();
      check("stop_t4_stays_idle", running, 0);

      // stop_req coincident with wrap: one more full cycle, run_req held high in STOPPING
      run_req = 1'b1;
      wait_running(1'b1, 20, "wrap_stop_enter_run");
      wait_ring(R_T9, 200, "wrap_stop_reach_t9");
      repeat (7) tick();
      stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
      check("wrap_stop_cycle_end", cycle_end, 1);
      check("wrap_stop_ring_t0", ring, R_T0);
      check("wrap_stop_still_running", running, 1);
      run_until_idle(200, "wrap_stop", adv, ce);
      run_req = 1'b0;
      check("wrap_stop_advances", adv, 10);
      check("wrap_stop_cycle_end_count", ce, 1);
      check("wrap_stop_ring", ring, R_T0);

      // run_req falling at T2 acts as a stop
      run_req = 1'b1;
      wait_running(1'b1, 20, "runfall_enter_run");
      wait_ring(R_T2, 100, "runfall_reach_t2");
      run_req = 1'b0;
      run_until_idle(200, "runfall", adv, ce);
      check("runfall_advances", adv, 8);
      check("runfall_cycle_end", ce, 1);

      // Stall: trigger held low while running
      run_req = 1'b1;
      wait_running(1'b1, 20, "stall_enter_run");
      wait_ring(R_T3, 100, "stall_reach_t3");
      trig_en = 1'b0;
      elapsed = 0;
      ce = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         elapsed++;
         if (cycle_end === 1'b1) ce++;
         if (stall_err === 1'b1) break;
      end
      check("stall_err_set", stall_err, 1);
      check("stall_ticks", elapsed, 17);
      check("stall_locked_cleared", locked, 0);
      check("stall_ring_t0", ring, R_T0);
      check("stall_running", running, 0);
      check("stall_no_cycle_end", ce, 0);
      repeat (5) tick();
      check("stall_err_sticky", stall_err, 1);
      check("stall_stays_idle", running, 0);

      // Relock, then reset mid-cycle at T6
      trig_en = 1'b1;
      wait_running(1'b1, 400, "relock_run");
      wait_ring(R_T6, 100, "reset_reach_t6");
      SYSRESET_N = 1'b0;
      #1;
      check("midrst_ring", ring, R_T0);
      check("midrst_running", running, 0);
      check("midrst_locked", locked, 0);
      check("midrst_stall_err", stall_err, 0);
      check("midrst_cycle_end", cycle_end, 0);
      tick();
      SYSRESET_N = 1'b1;
      bad = 0;
      run_ticks = 0;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         run_ticks++;
         if (running === 1'b1 && locked !== 1'b1) bad++;
         if (running === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("midrst_rerun", {31'd0, got}, 1);
      check("midrst_run_without_lock", bad, 0);
      check("midrst_relock_delay_ge16", {31'd0, run_ticks >= 16}, 1);
      run_req = 1'b0;
      run_until_idle(200, "midrst_stop", adv, ce);

      // Single cycle from locked IDLE
      single_cycle = 1'b1;
      tick();
      single_cycle = 1'b0;
      run_until_idle(200, "single", adv, ce);
      check("single_advances", adv, 10);
      check("single_cycle_end", ce, 1);
      check("single_ring", ring, R_T0);
      repeat (20) tick();
      check("single_stays_idle", running, 0);

`ifdef IBM1620_RING_CHECK_EN
      // Two ring bits set while running
      single_cycle = 1'b1;
      tick();
      single_cycle = 1'b0;
      check("chk_pre_running", running, 1);
      force dut.ring_q = 10'h003;
      #1;
      release dut.ring_q;
      tick();
      check("chk_err_set", ring_chk_err, 1);
      check("chk_ring_t0", ring, R_T0);
      check("chk_idle", running, 0);
      repeat (20) tick();
      check("chk_err_sticky", ring_chk_err, 1);
`else
      check("chk_err_tied_low", ring_chk_err, 0);
`endif

      // single_cycle before lock after reset is ignored and not latched
      pulse_reset();
      single_cycle = 1'b1;
      tick();
      single_cycle = 1'b0;
      check("unlocked_single_locked", locked, 0);
      run_ticks = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (running === 1'b1) run_ticks++;
      end
      check("unlocked_single_relocked", locked, 1);
      check("unlocked_single_never_ran", run_ticks, 0);
      check("unlocked_single_ring", ring, R_T0);

      // Trigger slower than the counter range: saturated intervals never lock
      trig_per = 300;
      pulse_reset();
      lock_ticks = 0;
      for (int i = 0; i < 1400; i++) begin
         tick();
         if (locked === 1'b1) lock_ticks++;
      end
      check("saturated_never_locks", lock_ticks, 0);
      check("saturated_idle", running, 0);
      trig_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ibm1620_timing_ring.md
Name: ibm1620_timing_ring

Overview:
- Receiving end of the oscillator/binary-trigger clock chain (TAF oscillator -> TAJ trigger).
- Samples the trigger output and locks to its period, then steps a one-hot timing ring of gate positions T0..T(RING_LEN-1), one position per trigger rising edge.
- Provides start/stop/single-cycle control and detects a stalled trigger, so downstream SMS-card logic gets clean memory-cycle timing gates.

Parameters:
- RING_LEN, 10, number of timing positions per memory cycle (T0..T9).
- PER_W, 8, width of the trigger-period counter, in SYSCLOCK ticks.
- LOCK_EDGES, 2, consecutive equal-period trigger edges required to declare lock.

Ports:
- SYSCLOCK  input  1  system simulation clock; all state on its rising edge.
- SYSRESET_N  input  1  asynchronous active-low reset.
- trig_q  input  1  binary-trigger output, asynchronous to the ring; synchronised internally.
- run_req  input  1  level; request free-running cycles.
- stop_req  input  1  one-tick pulse; stop at the next cycle end.
- single_cycle  input  1  one-tick pulse; run exactly one full cycle from IDLE.
- ring  output  RING_LEN  one-hot timing gates; bit 0 = T0.
- cycle_end  output  1  one-tick pulse on the T(last)->T0 advance.
- running  output  1  high in RUN and STOPPING.
- locked  output  1  period lock achieved.
- stall_err  output  1  sticky; trigger stalled while running.
- ring_chk_err  output  1  sticky one-hot check failure; see Optional Feature.

Behaviour:
- Reset: async, SYSRESET_N=0 forces state IDLE and ring=1 (T0). All other outputs go to 0, and all counters and sticky flags clear. Same result if asserted mid-cycle.
- trig_q passes through a 2-flop synchroniser. An edge event is sync_q & ~sync_q_d, so there are 3 SYSCLOCK ticks from a trig_q rise to the event.
- The period counter counts ticks between edge events and saturates at all-ones.
- Lock:
  - After LOCK_EDGES consecutive intervals with identical count, locked=1 and the count is stored as lock_per.
  - A differing interval resets the match count.
  - Lock is lost only on reset or stall.
- States:
  - IDLE: ring holds T0.
    - run_req=1 & locked -> RUN.
    - single_cycle & locked -> STOPPING (runs one full cycle).
    - Requests while unlocked are ignored (single_cycle is not latched).
  - RUN: each edge event rotates the ring left by one.
    - Wrap from T(last) to T0 pulses cycle_end in the same tick the ring shows T0.
    - stop_req, or run_req falling, is latched as pending stop -> STOPPING.
  - STOPPING: keeps advancing; on wrap, pulses cycle_end and goes to IDLE with ring=T0.
- Simultaneous events:
  - stop_req in the tick of a wrap applies to the next cycle, so one more full cycle runs.
  - run_req reasserted during STOPPING does not cancel the stop.
- Stall: in RUN/STOPPING, if the period counter reaches 2*lock_per+1 with no edge:
  - stall_err=1 and locked=0;
  - state -> IDLE, ring -> T0;
  - no cycle_end pulse.
- Saturated period counter (trigger absent at power-up) never locks.

Optional Feature:
- Macro IBM1620_RING_CHECK_EN.
- With it defined: every tick, ring is checked for exactly one bit set. On failure, ring_chk_err is set (sticky), state -> IDLE and ring -> T0.
- Without it: no check logic; ring_chk_err is tied 0.

Decomposition:
- Shared package ibm1620_timing_pkg holds:
  - state enum (IDLE, RUN, STOPPING);
  - RING_LEN default and T-position index constants (T0..T9).
- One sub-module, ibm1620_trig_sync: synchroniser, edge detector, period counter and lock logic. Outputs are edge, locked, lock_per and stall (stall takes a running input).

Test Plan:
- trig_q toggling with period 8 ticks, run_req=1 -> locked after 2 equal intervals; ring steps T0..T9 one position per edge; cycle_end every 80 ticks.
- Running; stop_req pulse at T4 -> finishes T5..T9, one cycle_end, IDLE with ring=T0, running=0.
- Locked IDLE; single_cycle pulse -> exactly 10 advances and one cycle_end, then IDLE; a second single_cycle before lock, after a reset, is ignored.
- Running, period 8; trig_q held low -> stall_err=1 after 17 ticks without an edge; locked=0; ring=T0; no cycle_end.
- SYSRESET_N pulsed low at T6 mid-cycle -> immediate ring=T0 and all flags 0; relock needed before run.
- With IBM1620_RING_CHECK_EN: force two ring bits set -> ring_chk_err=1 next tick, IDLE, ring=T0. Without the macro, ring_chk_err stays 0.
